// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared op and FSM state encodings for the multiply/divide unit
// Rev 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_FINISH = 2'b10
   } state_e;

   localparam logic [5:0] C_STEP_LAST = 6'd31;

   // Signed ops are MULT and DIV (op[0] clear); op[1] selects divide.
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative 32-step MULT/MULTU/DIV/DIVU with HI/LO registers
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] regSource,
   input  logic [WIDTH-1:0] regTarget,
   input  logic             hiWrite,
   input  logic             loWrite,
   input  logic [WIDTH-1:0] writeData,
   output logic             busy,
   output logic             done,
   output logic             divByZero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e               r_state;
   logic [5:0]           r_count;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_b;
   logic                 r_is_div;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic                 r_dbz_pend;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_dbz;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   logic                 w_a_neg;
   logic                 w_b_neg;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [WIDTH:0]       w_add;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [WIDTH:0]       w_rem_sh;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_sub;
   logic [2*WIDTH-1:0]   w_div_next;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;
   logic [WIDTH-1:0]     w_hi_res;
   logic [WIDTH-1:0]     w_lo_res;

   always_comb begin
      w_a_neg = op_is_signed(op) & regSource[WIDTH-1];
      w_b_neg = op_is_signed(op) & regTarget[WIDTH-1];
      w_a_mag = w_a_neg ? (~regSource + 1'b1) : regSource;
      w_b_mag = w_b_neg ? (~regTarget + 1'b1) : regTarget;
   end

   // Multiply: add multiplicand into the upper half when LSB is set, then shift right.
   always_comb begin
      w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
      w_mul_next = {w_add, r_acc[WIDTH-1:1]};
   end

   // Divide: shift left one bit into the remainder, subtract divisor if it fits.
   always_comb begin
      w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
      w_ge     = (w_rem_sh >= {1'b0, r_b});
      w_sub    = w_rem_sh[WIDTH-1:0] - r_b;
      if (w_ge) begin
         w_div_next = {w_sub, r_acc[WIDTH-2:0], 1'b1};
      end else begin
         w_div_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
      w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
      w_rem  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
      if (r_is_div) begin
         w_hi_res = w_rem;
         w_lo_res = w_quo;
      end else begin
         w_hi_res = w_prod[2*WIDTH-1:WIDTH];
         w_lo_res = w_prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_count    <= '0;
         r_acc      <= '0;
         r_b        <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dbz_pend <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_dbz      <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_busy   <= 1'b1;
                  r_count  <= '0;
                  r_is_div <= op_is_div(op);
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_b      <= op_is_div(op) ? w_b_mag : w_a_mag;
                  r_acc    <= {{WIDTH{1'b0}}, (op_is_div(op) ? w_a_mag : w_b_mag)};
                  if (op_is_div(op) && (regTarget == '0)) begin
                     r_dbz_pend <= 1'b1;
                     r_state    <= ST_FINISH;
                  end else begin
                     r_dbz_pend <= 1'b0;
                     r_state    <= ST_RUN;
                  end
               end else begin
                  if (hiWrite) r_hi <= writeData;
                  if (loWrite) r_lo <= writeData;
               end
            end
            ST_RUN: begin
               r_acc <= r_is_div ? w_div_next : w_mul_next;
               if (r_count == C_STEP_LAST) begin
                  r_state <= ST_FINISH;
               end else begin
                  r_count <= r_count + 6'd1;
               end
            end
            ST_FINISH: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
               if (r_dbz_pend) begin
                  r_dbz <= 1'b1;
               end else begin
                  r_hi <= w_hi_res;
                  r_lo <= w_lo_res;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign divByZero = r_dbz;
   assign hi        = r_hi;
   assign lo        = r_lo;

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1: request a new operation, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port regSource, input, 32: operand A (rs; multiplicand or dividend), from the register file.
REQ-007 The block SHALL have port regTarget, input, 32: operand B (rt; multiplier or divisor), from the register file.
REQ-008 The block SHALL have ports hiWrite and loWrite, input, 1 each: MTHI and MTLO strobes.
REQ-009 The block SHALL have port writeData, input, 32: data for MTHI and MTLO.
REQ-010 The block SHALL have port busy, output, 1: high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1: one-cycle pulse marking completion.
REQ-012 The block SHALL have port divByZero, output, 1: valid with done; high when a DIV or DIVU divisor was 0.
REQ-013 The block SHALL have ports hi and lo, output, 32 each: registered HI and LO, for MFHI and MFLO.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and FINISH.
REQ-015 In IDLE, start=1 at edge E0 SHALL latch op and operand magnitudes, record the result signs, clear the step counter, enter RUN and set busy.
REQ-016 For a signed op, a negative operand SHALL be replaced by its two's-complement magnitude; unsigned ops SHALL use operands as-is.
REQ-017 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per edge, for exactly 32 steps (E1..E32), then enter FINISH.
REQ-018 At FINISH (E33), HI/LO SHALL be written with the sign-corrected result, done SHALL be 1 for exactly one cycle, busy SHALL go to 0, and the FSM SHALL return to IDLE.
REQ-019 Multiply SHALL write the 64-bit product as HI = bits 63:32 and LO = bits 31:0.
REQ-020 Divide SHALL write LO = quotient and HI = remainder.
REQ-021 Signed divide SHALL truncate toward zero, and the remainder sign SHALL follow the dividend.
REQ-022 Signed divide 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0, with no flag.
REQ-023 DIV or DIVU with regTarget=0 SHALL go directly IDLE->FINISH, leave HI/LO unchanged, and assert divByZero and done at E1.
REQ-024 start while busy SHALL be ignored; the latched operands SHALL be unaffected by later changes to regSource and regTarget.
REQ-025 hiWrite/loWrite in IDLE with start=0 SHALL load writeData into HI/LO at that edge; both strobes together SHALL load both.
REQ-026 hiWrite/loWrite while busy, or in the same cycle as an accepted start, SHALL be ignored.
REQ-027 hi and lo SHALL hold their value between updates and SHALL never show partial results during RUN.
REQ-028 divByZero SHALL be 0 whenever done is 0.
REQ-029 The step counter SHALL be 6 bits and SHALL be compared for equality with 31, with no wrap-around.

Reset
REQ-030 rst=1 SHALL force, immediately and regardless of clk, state=IDLE, busy=0, done=0, divByZero=0, hi=0, lo=0, and counter=0.
REQ-031 Reset during RUN or FINISH SHALL abandon the operation with no done pulse.
REQ-032 A start at the first edge after rst falls SHALL be accepted normally.

Structure
REQ-033 The op encodings (MULT, MULTU, DIV, DIVU) and the FSM state encoding SHALL reside in shared package muldiv_pkg, which the decoder also imports.
REQ-034 The datapath SHALL be a single 64-bit {remainder/HI, quotient/LO} shift register plus a 32-bit latched divisor/multiplicand.
REQ-035 No sub-module SHALL be used; sign conversion and correction SHALL be local logic.

Verification
REQ-036 MULT: -3 (0xFFFFFFFD) x 7 -> done at E33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high E0..E32.
REQ-037 MULTU: 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-038 DIV: -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU 100 / 7 -> LO=14, HI=2.
REQ-039 After MTHI 0x1234 and MTLO 0x5678, DIVU 100 / 0 -> done and divByZero at E1; HI=0x1234, LO=0x5678 unchanged.
REQ-040 Start MULT, then at E5 drive start=1 and hiWrite=1 with new operands -> both ignored; the result reflects the original operands.
REQ-041 Assert rst at E10 of RUN -> busy, hi and lo are 0 immediately and no done pulse occurs; a MULTU 6 x 7 started next edge -> LO=42.
